// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int MAX_CH    = 8;

    // A programmed half-period of zero runs the channel at the fastest rate.
    function automatic logic [31:0] sat_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, shadow/active half registers, clk_out and tick.
// The tick register exists only when CLK_DIV_TICK_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_HALF = '1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] half_eff;
    logic             clk_q, clk_d;
    logic             rise;

    // Sync and stop both restart the half-period and adopt the newest shadow value.
    always_comb begin
        half_eff = CNT_W'(sat_half(32'(active_q)));
        shadow_d = wr ? wr_half : shadow_q;
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        active_d = active_q;
        rise     = 1'b0;
        if (sync || !run) begin
            cnt_d    = '0;
            clk_d    = 1'b0;
            active_d = shadow_d;
        end else if (cnt_q == half_eff - ONE) begin
            cnt_d    = '0;
            clk_d    = ~clk_q;
            active_d = shadow_q;
            rise     = ~clk_q;
        end else begin
            cnt_d    = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            shadow_q <= DEF_HALF;
            active_q <= DEF_HALF;
            clk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            clk_q    <= clk_d;
        end
    end

    assign clk_out = clk_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = rise;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    logic unused_rise;
    assign unused_rise = rise;
    assign tick        = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, enable register, per-channel dividers.
// Define CLK_DIV_TICK_EN to get a registered one-cycle tick on every clk_out rising edge.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                      N_CH     = 2,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [N_CH*CNT_W-1:0]   DEF_HALF = {16'd50000, 16'd500},
    parameter logic [N_CH-1:0]         EN_RST   = {N_CH{1'b1}}
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_en,
    input  logic                       cfg_we,
    input  logic [$clog2(MAX_CH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]           cfg_half,
    input  logic                       sync,
    output logic [N_CH-1:0]            clk_out,
    output logic [N_CH-1:0]            tick
);

    logic [N_CH-1:0] en_q, en_d;

    // The enable register only changes through reset; ch_en gates it at run time.
    always_comb begin
        en_d = en_q;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            en_q <= EN_RST;
        end else begin
            en_q <= en_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == ($clog2(MAX_CH))'(i));

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_in  (clk_in),
            .rst     (rst),
            .run     (en_q[i] & ch_en[i]),
            .sync    (sync),
            .wr      (wr),
            .wr_half (cfg_half),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized scoreboard bench for clk_div_multi against an edge-deadline reference model.
module tb_clk_div_multi;

    localparam int N_CH  = 3;
    localparam int CNT_W = 16;
    localparam logic [N_CH*CNT_W-1:0] DEF = {16'd40, 16'd25, 16'd7};

    logic              clk_in = 1'b0;
    logic              rst    = 1'b0;
    logic [N_CH-1:0]   ch_en  = '1;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
    logic              sync   = 1'b0;
    logic [N_CH-1:0]   clk_out;
    logic [N_CH-1:0]   tick;

    always #5 clk_in = ~clk_in;

    clk_div_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF),
        .EN_RST   ({N_CH{1'b1}})
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .ch_en    (ch_en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    typedef struct {
        logic [N_CH-1:0] clk;
        logic [N_CH-1:0] tck;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Reference model: each channel's next toggle is at edge anchor + H.
    int unsigned m_shadow[N_CH];
    int unsigned m_active[N_CH];
    logic        m_level[N_CH];
    longint      m_anchor[N_CH];
    longint      edge_idx;

    function automatic int unsigned sat(input int unsigned h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_shadow[i] = int'(DEF[i*CNT_W +: CNT_W]);
            m_active[i] = m_shadow[i];
            m_level[i]  = 1'b0;
            m_anchor[i] = -1;
        end
        edge_idx = 0;
    endtask

    task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                               input logic [N_CH-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n_cycles);
        exp_t        pend;
        logic        wr;
        logic        tk;
        int unsigned new_shadow;
        int          r;
        for (int c = 0; c < n_cycles; c++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(0, 99) == 0) ch_en[i] = ~ch_en[i];
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            cfg_half = (r == 0) ? 16'd0 : (r == 1) ? 16'd1 : 16'($urandom_range(2, 40));
            sync = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N_CH; i++) begin
                wr = cfg_we && (int'(cfg_ch) == i);
                new_shadow = wr ? int'(cfg_half) : m_shadow[i];
                tk = 1'b0;
                if (sync || !ch_en[i]) begin
                    m_shadow[i] = new_shadow;
                    m_active[i] = new_shadow;
                    m_level[i]  = 1'b0;
                    m_anchor[i] = edge_idx;
                end else begin
                    if (edge_idx == m_anchor[i] + longint'(sat(m_active[i]))) begin
                        m_level[i]  = ~m_level[i];
                        tk          = m_level[i];
                        m_active[i] = m_shadow[i];
                        m_anchor[i] = edge_idx;
                    end
                    m_shadow[i] = new_shadow;
                end
                pend.clk[i] = m_level[i];
`ifdef CLK_DIV_TICK_EN
                pend.tck[i] = tk;
`else
                pend.tck[i] = 1'b0;
`endif
            end
            @(posedge clk_in);
            #1;
            exp_q.push_back(pend);
            edge_idx++;
        end
        cfg_we = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(negedge clk_in);
            w++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare whatever the scoreboard expects for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("clk_out", clk_out, e.clk);
                checkOutput("tick", tick, e.tck);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset_clk_out", clk_out, '0);
        checkOutput("reset_tick", tick, '0);

        @(posedge clk_in);
        #1;
        ch_en = '1;
        rst = 1'b1;
        model_reset();
        applyStimulus(3000);
        drain();

        // Asynchronous reset assertion between clock edges.
        ch_en = '1;
        repeat (37) @(posedge clk_in);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_clk_out", clk_out, '0);
        checkOutput("async_rst_tick", tick, '0);

        repeat (2) @(posedge clk_in);
        #1;
        ch_en = '1;
        rst = 1'b1;
        model_reset();
        applyStimulus(3000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
